// File: rtl/register_file_param.sv
// Parametrised register file: DEPTH x WIDTH storage, one write port, two
// registered read ports with same-edge write/clear bypass, and a sequenced
// clear engine that zeroes one register per cycle while busy is high.
module register_file_param #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_valid_b,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              clr_done_q;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];

  logic [WIDTH-1:0]  rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0]  rd_data_b_q, rd_data_b_d;
  logic              rd_valid_a_q, rd_valid_a_d;
  logic              rd_valid_b_q, rd_valid_b_d;

  logic              wr_acc;
  logic              clr_act;

  // An address is backed by storage when in range and not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_X) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  // Value a read of addr would capture on this edge, including bypass of an
  // accepted write and of the register the clear engine is zeroing.
  function automatic logic [WIDTH-1:0] read_val(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] v;
    v = '0;
    if (addr_ok(addr)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr == ADDR_W'(i)) v = mem_q[i];
      end
      if (wr_acc && (wr_addr == addr)) v = wr_data;
      if (clr_act && (ADDR_W'(cnt_q) == addr)) v = '0;
    end
    return v;
  endfunction

  assign clr_act = (state_q == CLEAR);
  // Writes are locked out for the whole clear; the start edge itself still
  // accepts a write because busy is not yet high.
  assign wr_acc  = wr_en && !busy_q && addr_ok(wr_addr);

  // Next array contents: accepted write, then the clear engine's zeroing.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_acc && (wr_addr == ADDR_W'(i))) mem_d[i] = wr_data;
      if (clr_act && (cnt_q == CNT_W'(i)))   mem_d[i] = '0;
    end
    if (ZERO_REG != 0) mem_d[0] = '0;
  end

  // Read ports: load on rd_en, otherwise hold data and drop valid.
  always_comb begin
    rd_valid_a_d = rd_en_a;
    rd_valid_b_d = rd_en_b;
    rd_data_a_d  = rd_en_a ? read_val(rd_addr_a) : rd_data_a_q;
    rd_data_b_d  = rd_en_b ? read_val(rd_addr_b) : rd_data_b_q;
  end

  // Storage and read-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
    end
  end

  // Clear sequencer: walks cnt from 0 to DEPTH-1, then pulses clr_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          clr_done_q <= 1'b0;
          if (clr_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_q == CNT_LAST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            cnt_q      <= cnt_q + 1'b1;
            clr_done_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          busy_q     <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_valid_b = rd_valid_b_q;
  assign busy       = busy_q;
  assign clr_done   = clr_done_q;

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param across three configurations:
// default 4x4, DEPTH=3 with hardwired zero register, and 16-bit x 8.
module tb_register_file_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Config 0: WIDTH=4 DEPTH=4 ADDR_W=2 ZERO_REG=0
  logic wr_en0, rd_en_a0, rd_en_b0, rd_valid_a0, rd_valid_b0, clr_start0, busy0, clr_done0;
  logic [1:0] wr_addr0, rd_addr_a0, rd_addr_b0;
  logic [3:0] wr_data0, rd_data_a0, rd_data_b0;
  // Config 1: WIDTH=4 DEPTH=3 ADDR_W=2 ZERO_REG=1
  logic wr_en1, rd_en_a1, rd_en_b1, rd_valid_a1, rd_valid_b1, clr_start1, busy1, clr_done1;
  logic [1:0] wr_addr1, rd_addr_a1, rd_addr_b1;
  logic [3:0] wr_data1, rd_data_a1, rd_data_b1;
  // Config 2: WIDTH=16 DEPTH=8 ADDR_W=3 ZERO_REG=0
  logic wr_en2, rd_en_a2, rd_en_b2, rd_valid_a2, rd_valid_b2, clr_start2, busy2, clr_done2;
  logic [2:0] wr_addr2, rd_addr_a2, rd_addr_b2;
  logic [15:0] wr_data2, rd_data_a2, rd_data_b2;

  register_file_param #(.WIDTH(4), .DEPTH(4), .ADDR_W(2), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .rd_en_a(rd_en_a0), .rd_addr_a(rd_addr_a0), .rd_data_a(rd_data_a0), .rd_valid_a(rd_valid_a0),
    .rd_en_b(rd_en_b0), .rd_addr_b(rd_addr_b0), .rd_data_b(rd_data_b0), .rd_valid_b(rd_valid_b0),
    .clr_start(clr_start0), .busy(busy0), .clr_done(clr_done0));

  register_file_param #(.WIDTH(4), .DEPTH(3), .ADDR_W(2), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .rd_en_a(rd_en_a1), .rd_addr_a(rd_addr_a1), .rd_data_a(rd_data_a1), .rd_valid_a(rd_valid_a1),
    .rd_en_b(rd_en_b1), .rd_addr_b(rd_addr_b1), .rd_data_b(rd_data_b1), .rd_valid_b(rd_valid_b1),
    .clr_start(clr_start1), .busy(busy1), .clr_done(clr_done1));

  register_file_param #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .rd_en_a(rd_en_a2), .rd_addr_a(rd_addr_a2), .rd_data_a(rd_data_a2), .rd_valid_a(rd_valid_a2),
    .rd_en_b(rd_en_b2), .rd_addr_b(rd_addr_b2), .rd_data_b(rd_data_b2), .rd_valid_b(rd_valid_b2),
    .clr_start(clr_start2), .busy(busy2), .clr_done(clr_done2));

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [15:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=%0h expected=queued entry", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    {wr_en0, rd_en_a0, rd_en_b0, clr_start0} = '0;
    {wr_addr0, rd_addr_a0, rd_addr_b0, wr_data0} = '0;
    {wr_en1, rd_en_a1, rd_en_b1, clr_start1} = '0;
    {wr_addr1, rd_addr_a1, rd_addr_b1, wr_data1} = '0;
    {wr_en2, rd_en_a2, rd_en_b2, clr_start2} = '0;
    {wr_addr2, rd_addr_a2, rd_addr_b2, wr_data2} = '0;

    // Mid-cycle asynchronous reset: outputs clear without a clock edge.
    tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_rd_data_a0", rd_data_a0, 0);
    chk("rst_rd_valid_a0", rd_valid_a0, 0);
    chk("rst_rd_data_b0", rd_data_b0, 0);
    chk("rst_rd_valid_b0", rd_valid_b0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_clr_done0", clr_done0, 0);
    chk("rst_rd_data_a2", rd_data_a2, 0);
    tick();
    rst_n = 1'b1;

    // Basic write then read with one-cycle latency; idle port B stays invalid.
    wr_en0 = 1; wr_addr0 = 2; wr_data0 = 4'hA;
    tick();
    wr_en0 = 0;
    rd_en_a0 = 1; rd_addr_a0 = 2;
    push("basic_rd_a", 16'hA); push("basic_vld_a", 1); push("idle_vld_b", 0);
    tick();
    pop_cmp(rd_data_a0); pop_cmp(rd_valid_a0); pop_cmp(rd_valid_b0);
    rd_en_a0 = 0;
    push("hold_rd_a", 16'hA); push("hold_vld_a", 0);
    tick();
    pop_cmp(rd_data_a0); pop_cmp(rd_valid_a0);

    // Same-edge write bypass to both ports; never-written address reads 0.
    wr_en0 = 1; wr_addr0 = 1; wr_data0 = 4'h5;
    rd_en_a0 = 1; rd_addr_a0 = 1; rd_en_b0 = 1; rd_addr_b0 = 1;
    push("bypass_rd_a", 16'h5); push("bypass_vld_a", 1);
    push("bypass_rd_b", 16'h5); push("bypass_vld_b", 1);
    tick();
    pop_cmp(rd_data_a0); pop_cmp(rd_valid_a0); pop_cmp(rd_data_b0); pop_cmp(rd_valid_b0);
    wr_en0 = 0; rd_en_b0 = 0; rd_addr_a0 = 3;
    push("unwritten_rd3", 16'h0);
    tick();
    pop_cmp(rd_data_a0);
    rd_en_a0 = 0;

    // Fill with 0xF, then run a clear.
    for (int i = 0; i < 4; i++) begin
      wr_en0 = 1; wr_addr0 = 2'(i); wr_data0 = 4'hF;
      tick();
    end
    wr_en0 = 0;
    clr_start0 = 1;
    tick();
    clr_start0 = 0;
    chk("clr_busy_c1", busy0, 1);
    chk("clr_done_c1", clr_done0, 0);
    tick();
    chk("clr_busy_c2", busy0, 1);
    wr_en0 = 1; wr_addr0 = 0; wr_data0 = 4'h5;
    rd_en_a0 = 1; rd_addr_a0 = 3;
    push("clr_uncleared_rd3", 16'hF);
    tick();
    pop_cmp(rd_data_a0);
    chk("clr_busy_c3", busy0, 1);
    wr_en0 = 0; rd_addr_a0 = 2;
    push("clr_bypass_rd2", 16'h0);
    tick();
    pop_cmp(rd_data_a0);
    chk("clr_busy_c4", busy0, 1);
    chk("clr_done_c4", clr_done0, 0);
    rd_en_a0 = 0;
    tick();
    chk("clr_busy_end", busy0, 0);
    chk("clr_done_pulse", clr_done0, 1);
    tick();
    chk("clr_done_drop", clr_done0, 0);
    for (int i = 0; i < 4; i++) begin
      rd_en_a0 = 1; rd_addr_a0 = 2'(i); rd_en_b0 = 1; rd_addr_b0 = 2'(i);
      push("cleared_rd_a", 16'h0); push("cleared_rd_b", 16'h0);
      tick();
      pop_cmp(rd_data_a0); pop_cmp(rd_data_b0);
    end
    rd_en_a0 = 0; rd_en_b0 = 0;

    // ZERO_REG=1, DEPTH=3: addr 0 and addr 3 writes dropped, reads return 0.
    wr_en1 = 1; wr_addr1 = 0; wr_data1 = 4'h7; rd_en_a1 = 1; rd_addr_a1 = 0;
    push("zr_bypass_rd0", 16'h0);
    tick();
    pop_cmp(rd_data_a1);
    wr_addr1 = 3; wr_data1 = 4'h9; rd_addr_a1 = 3;
    push("oob_bypass_rd3", 16'h0);
    tick();
    pop_cmp(rd_data_a1);
    wr_addr1 = 2; wr_data1 = 4'h6; rd_en_a1 = 0;
    tick();
    wr_en1 = 0;
    rd_en_a1 = 1; rd_addr_a1 = 0; rd_en_b1 = 1; rd_addr_b1 = 3;
    push("zr_rd0", 16'h0); push("zr_vld0", 1); push("oob_rd3", 16'h0); push("oob_vld3", 1);
    tick();
    pop_cmp(rd_data_a1); pop_cmp(rd_valid_a1); pop_cmp(rd_data_b1); pop_cmp(rd_valid_b1);
    rd_addr_a1 = 2; rd_en_b1 = 0;
    push("zr_cfg_rd2", 16'h6);
    tick();
    pop_cmp(rd_data_a1);
    rd_en_a1 = 0;
    clr_start1 = 1;
    tick();
    clr_start1 = 0;
    for (int i = 0; i < 3; i++) begin
      chk("d3_clr_busy", busy1, 1);
      tick();
    end
    chk("d3_clr_busy_end", busy1, 0);
    chk("d3_clr_done", clr_done1, 1);
    rd_en_a1 = 1; rd_addr_a1 = 2;
    push("d3_cleared_rd2", 16'h0);
    tick();
    pop_cmp(rd_data_a1);
    rd_en_a1 = 0;

    // WIDTH=16, DEPTH=8.
    wr_en2 = 1; wr_addr2 = 7; wr_data2 = 16'hBEEF;
    tick();
    wr_en2 = 0; rd_en_a2 = 1; rd_addr_a2 = 7;
    push("w16_rd7", 16'hBEEF); push("w16_vld7", 1);
    tick();
    pop_cmp(rd_data_a2); pop_cmp(rd_valid_a2);
    rd_en_a2 = 0;
    clr_start2 = 1;
    tick();
    clr_start2 = 0;
    n = 0;
    while (busy2 && n < 20) begin
      n++;
      tick();
    end
    chk("w16_busy_cycles", 16'(n), 16'd8);
    chk("w16_clr_done", clr_done2, 1);
    rd_en_a2 = 1; rd_addr_a2 = 7;
    push("w16_cleared_rd7", 16'h0);
    tick();
    pop_cmp(rd_data_a2);
    rd_en_a2 = 0;

    // clr_start held high: second clear starts right after clr_done.
    clr_start0 = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("b2b_busy", busy0, 1);
      tick();
    end
    chk("b2b_busy_gap", busy0, 0);
    chk("b2b_done", clr_done0, 1);
    tick();
    chk("b2b_restart_busy", busy0, 1);
    chk("b2b_restart_done", clr_done0, 0);
    clr_start0 = 0;
    tick();
    chk("abort_busy_pre", busy0, 1);
    // Reset in the 2nd clear cycle aborts without a clr_done pulse.
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy0, 0);
    chk("abort_done", clr_done0, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_done", clr_done0, 0);
      chk("abort_idle", busy0, 0);
    end

    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
